// File: rtl/imem_loader.sv
// Byte-serial program loader: packs a big-endian byte stream into 32-bit words
// and writes them to instruction memory from word address 0, with done/error status.
module imem_loader #(
   parameter int ADDR_WIDTH = 6,
   parameter int DEPTH      = 18
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [7:0]            in_data,
   input  logic                  in_valid,
   input  logic                  in_last,
   output logic                  in_ready,
   output logic                  we,
   output logic [ADDR_WIDTH-1:0] wa,
   output logic [31:0]           wd,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [ADDR_WIDTH:0]   word_count
);

   typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

   state_t                state, state_nx;
   logic [ADDR_WIDTH-1:0] addr;
   logic [1:0]            bcnt;
   logic [31:0]           sr;
   logic                  last_q;
   logic                  accept, word_end, at_end;
   logic [31:0]           word_nx;

   assign accept   = (state == LOAD) && in_valid;
   assign word_end = accept && ((bcnt == 2'd3) || in_last);
   assign at_end   = (addr == LAST_ADDR);
   // Byte n of a word lands at bits [31-8n -: 8]; unfilled low bytes stay zero.
   assign word_nx  = sr | ({24'd0, in_data} << (5'd24 - {bcnt, 3'b000}));

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // Handshake and status outputs decode from the registered state only.
   always_comb begin
      state_nx = state;
      in_ready = 1'b0;
      we       = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      case (state)
         IDLE: if (start) state_nx = LOAD;
         LOAD: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            if (word_end) state_nx = WRITE;
         end
         WRITE: begin
            we       = 1'b1;
            busy     = 1'b1;
            state_nx = (last_q || at_end) ? DONE : LOAD;
         end
         DONE: begin
            done = 1'b1;
            if (start) state_nx = LOAD;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         addr       <= '0;
         bcnt       <= '0;
         sr         <= '0;
         last_q     <= 1'b0;
         wa         <= '0;
         wd         <= '0;
         word_count <= '0;
         error      <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  addr       <= '0;
                  bcnt       <= '0;
                  sr         <= '0;
                  last_q     <= 1'b0;
                  word_count <= '0;
                  error      <= 1'b0;
               end
            end
            LOAD: begin
               if (word_end) begin
                  // wa/wd only move here, so they hold steady outside the write strobe.
                  wa     <= addr;
                  wd     <= word_nx;
                  last_q <= in_last;
                  if (in_last && bcnt != 2'd3) error <= 1'b1;
               end else if (accept) begin
                  sr   <= word_nx;
                  bcnt <= bcnt + 2'd1;
               end
            end
            WRITE: begin
               addr       <= addr + 1'b1;
               word_count <= word_count + 1'b1;
               bcnt       <= '0;
               sr         <= '0;
               // Memory full before the image ended.
               if (!last_q && at_end) error <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: randomized byte streams with gaps, compared
// against a word-packing reference model of the expected memory writes and status.
module tb_imem_loader;
   localparam int AW    = 6;
   localparam int DEPTH = 18;

   logic          clk = 1'b0;
   logic          reset, start, in_valid, in_last;
   logic [7:0]    in_data;
   logic          in_ready, we, busy, done, error;
   logic [AW-1:0] wa;
   logic [31:0]   wd;
   logic [AW:0]   word_count;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   imem_loader #(.ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .start(start), .in_data(in_data),
      .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
      .we(we), .wa(wa), .wd(wd), .busy(busy), .done(done),
      .error(error), .word_count(word_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // write monitor
   logic [AW-1:0] got_wa[$];
   logic [31:0]   got_wd[$];
   int            bad_ready;
   int            first_we;
   always @(negedge clk) begin
      if (we) begin
         got_wa.push_back(wa);
         got_wd.push_back(wd);
         if (in_ready) bad_ready++;
         if (first_we < 0) first_we = cyc;
      end
   end

   // image and reference model
   logic [7:0]  img[$];
   bit          img_last;
   logic [31:0] exp_wd[$];
   bit          exp_err;
   int          exp_n;
   int          t0, t_done;
   bit          tmo;

   function automatic void build_model();
      int n  = img.size();
      int nw = img_last ? (n + 3) / 4 : n / 4;
      exp_wd.delete();
      if (nw > DEPTH) begin
         nw      = DEPTH;
         exp_err = 1'b1;
      end else begin
         exp_err = img_last && (n % 4 != 0);
      end
      for (int w = 0; w < nw; w++) begin
         logic [31:0] word = 32'h0;
         for (int b = 0; b < 4; b++)
            word = {word[23:0], (4*w + b < n) ? img[4*w + b] : 8'h00};
         exp_wd.push_back(word);
      end
      exp_n = nw;
   endfunction

   function automatic int write_diffs();
      int d = (got_wd.size() != exp_wd.size()) ? 1 : 0;
      int m = (got_wd.size() < exp_wd.size()) ? got_wd.size() : exp_wd.size();
      for (int i = 0; i < m; i++)
         if (got_wd[i] !== exp_wd[i] || got_wa[i] !== AW'(i)) d++;
      return d;
   endfunction

   task automatic clear_mon();
      got_wa.delete();
      got_wd.delete();
      bad_ready = 0;
      first_we  = -1;
      tmo       = 1'b0;
   endtask

   task automatic rand_image(input int n, input bit last);
      img.delete();
      for (int i = 0; i < n; i++) img.push_back(8'($urandom));
      img_last = last;
   endtask

   task automatic do_start();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      t0 = cyc;
   endtask

   task automatic drive_image(input int gap, input int sa, input int sb, input int maxb);
      int idx = 0;
      int guard = 0;
      int lim = (maxb < img.size()) ? maxb : img.size();
      bit acc;
      while (idx < lim && !done && guard < 3000) begin
         in_valid = ($urandom_range(99) >= gap);
         if (in_valid) begin
            in_data = img[idx];
            in_last = img_last && (idx == img.size() - 1);
         end else begin
            in_data = 8'($urandom);
            in_last = 1'($urandom);
         end
         start = (idx == sa || idx == sb);
         acc   = in_valid && in_ready;
         @(negedge clk);
         if (acc) idx++;
         guard++;
      end
      start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
      if (guard >= 3000) tmo = 1'b1;
   endtask

   task automatic wait_done();
      int g = 0;
      while (!done && g < 50) begin
         @(negedge clk);
         g++;
      end
      t_done = cyc;
      if (!done) tmo = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) begin
         @(negedge clk);
         start = 1'($urandom); in_valid = 1'($urandom);
         in_last = 1'($urandom); in_data = 8'($urandom);
      end
      @(negedge clk);
      checks++;
      if ({we, busy, done, error, in_ready} !== 5'b0) begin
         errors++; $display("FAIL reset_ctrl: got %b want 00000", {we, busy, done, error, in_ready});
      end
      checks++;
      if (wa !== '0 || wd !== 32'h0) begin
         errors++; $display("FAIL reset_addr_data: got wa=%0d wd=%h want 0/0", wa, wd);
      end
      checks++;
      if (word_count !== '0) begin
         errors++; $display("FAIL reset_wc: got %0d want 0", word_count);
      end
      reset = 1'b0; start = 1'b0;
      clear_mon();
      repeat (10) begin
         @(negedge clk);
         in_valid = 1'($urandom); in_last = 1'($urandom); in_data = 8'($urandom);
      end
      in_valid = 1'b0; in_last = 1'b0;
      checks++;
      if (got_wd.size() != 0 || busy !== 1'b0) begin
         errors++; $display("FAIL reset_idle_we: got %0d writes busy=%b want 0/0", got_wd.size(), busy);
      end
   endtask

   task automatic test_two_word();
      img = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h0C};
      img_last = 1'b1;
      build_model();
      clear_mon();
      do_start();
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b1) begin
         errors++; $display("FAIL two_word_ready: got ready=%b busy=%b want 1/1", in_ready, busy);
      end
      drive_image(0, -1, -1, 1000);
      wait_done();
      checks++;
      if (tmo || write_diffs() != 0) begin
         errors++; $display("FAIL two_word_writes: got %0d writes tmo=%0d want %0d exact", got_wd.size(), tmo, exp_n);
      end
      checks++;
      if (bad_ready != 0) begin
         errors++; $display("FAIL two_word_ready_in_write: got %0d want 0", bad_ready);
      end
      checks++;
      if (first_we - t0 != 4 || t_done - t0 != 10) begin
         errors++; $display("FAIL two_word_latency: got we@%0d done@%0d want 4/10", first_we - t0, t_done - t0);
      end
      checks++;
      if (done !== 1'b1 || error !== 1'b0 || word_count !== 7'd2) begin
         errors++; $display("FAIL two_word_status: got done=%b err=%b wc=%0d want 1/0/2", done, error, word_count);
      end
   endtask

   task automatic run_and_check(input string name, input int gap);
      build_model();
      clear_mon();
      do_start();
      drive_image(gap, -1, -1, 1000);
      wait_done();
      checks++;
      if (tmo || write_diffs() != 0 || bad_ready != 0) begin
         errors++; $display("FAIL %s_writes: got %0d writes tmo=%0d badrdy=%0d want %0d", name, got_wd.size(), tmo, bad_ready, exp_n);
      end
      checks++;
      if (done !== 1'b1 || error !== exp_err || word_count !== 7'(exp_n)) begin
         errors++; $display("FAIL %s_status: got done=%b err=%b wc=%0d want 1/%b/%0d", name, done, error, word_count, exp_err, exp_n);
      end
   endtask

   task automatic test_gaps();
      img = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h0C};
      img_last = 1'b1;
      for (int i = 0; i < 3; i++) run_and_check("gaps", 50);
   endtask

   task automatic test_partial();
      img = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
      img_last = 1'b1;
      run_and_check("partial", 30);
   endtask

   task automatic test_overflow();
      int rdy = 0;
      rand_image(19 * 4, 1'b0);
      run_and_check("overflow", 20);
      in_valid = 1'b1;
      repeat (10) begin
         in_data = 8'($urandom);
         @(negedge clk);
         if (in_ready) rdy++;
      end
      in_valid = 1'b0;
      checks++;
      if (rdy != 0 || got_wd.size() != DEPTH) begin
         errors++; $display("FAIL overflow_hold: got ready_cycles=%0d writes=%0d want 0/%0d", rdy, got_wd.size(), DEPTH);
      end
   endtask

   task automatic test_abort_restart();
      rand_image(8, 1'b1);
      clear_mon();
      do_start();
      drive_image(0, -1, -1, 2);
      in_valid = 1'b1; in_data = 8'($urandom);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      repeat (12) begin
         in_data = 8'($urandom);
         @(negedge clk);
      end
      in_valid = 1'b0;
      checks++;
      if (got_wd.size() != 0 || busy !== 1'b0 || done !== 1'b0) begin
         errors++; $display("FAIL abort_no_we: got writes=%0d busy=%b done=%b want 0/0/0", got_wd.size(), busy, done);
      end
      // start pulses during LOAD (byte 2) and WRITE (after byte 4) must be ignored
      rand_image(12, 1'b1);
      build_model();
      clear_mon();
      do_start();
      drive_image(0, 2, 4, 1000);
      wait_done();
      checks++;
      if (tmo || write_diffs() != 0 || word_count !== 7'd3 || error !== 1'b0) begin
         errors++; $display("FAIL midload_start: got writes=%0d wc=%0d err=%b want 3/3/0", got_wd.size(), word_count, error);
      end
      rand_image(5, 1'b1);
      run_and_check("restart_pre", 0);
      rand_image(8, 1'b1);
      build_model();
      clear_mon();
      do_start();
      checks++;
      if (word_count !== '0 || error !== 1'b0 || in_ready !== 1'b1 || done !== 1'b0) begin
         errors++; $display("FAIL restart_clear: got wc=%0d err=%b rdy=%b done=%b want 0/0/1/0", word_count, error, in_ready, done);
      end
      drive_image(10, -1, -1, 1000);
      wait_done();
      checks++;
      if (tmo || write_diffs() != 0 || word_count !== 7'd2 || error !== 1'b0) begin
         errors++; $display("FAIL restart_writes: got writes=%0d wc=%0d err=%b want 2/2/0", got_wd.size(), word_count, error);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 6; i++) begin
         rand_image($urandom_range(40, 1), 1'b1);
         run_and_check("random", $urandom_range(60));
      end
      rand_image(DEPTH * 4, 1'b1);
      run_and_check("exact_fit", 25);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
      first_we = -1; bad_ready = 0; tmo = 1'b0;
      test_reset();
      test_two_word();
      test_gaps();
      test_partial();
      test_overflow();
      test_abort_restart();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
